ir_command_scheduler: RTL and testbench

//  Upstream feeder of the IR transmitter state machine. Synchronises and debounces the four
//  raw direction buttons and resolves them to one of 9 legal direction codes.

---
 rtl/ir_pkg.sv | 36 +++
 rtl/ir_debouncer.sv | 56 +++++
 rtl/ir_command_scheduler.sv | 120 ++++++++++++
 tb/tb_ir_command_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared direction codes, bit positions and the conflict resolver for the
// IR command scheduler.
package ir_pkg;

  // Direction codes, bit order {F,B,L,R}
  localparam logic [3:0] IR_IDLE       = 4'b0000;
  localparam logic [3:0] IR_FWD        = 4'b1000;
  localparam logic [3:0] IR_BACK       = 4'b0100;
  localparam logic [3:0] IR_LEFT       = 4'b0010;
  localparam logic [3:0] IR_RIGHT      = 4'b0001;
  localparam logic [3:0] IR_FWD_LEFT   = 4'b1010;
  localparam logic [3:0] IR_FWD_RIGHT  = 4'b1001;
  localparam logic [3:0] IR_BACK_LEFT  = 4'b0110;
  localparam logic [3:0] IR_BACK_RIGHT = 4'b0101;

  localparam int IR_BIT_F = 3;
  localparam int IR_BIT_B = 2;
  localparam int IR_BIT_L = 1;
  localparam int IR_BIT_R = 0;

  // Opposing buttons cancel, so the result is always one of the 9 legal codes
  function automatic logic [3:0] ir_resolve(input logic [3:0] raw);
    logic [3:0] r;
    r = raw;
    if (raw[IR_BIT_F] && raw[IR_BIT_B]) begin
      r[IR_BIT_F] = 1'b0;
      r[IR_BIT_B] = 1'b0;
    end
    if (raw[IR_BIT_L] && raw[IR_BIT_R]) begin
      r[IR_BIT_L] = 1'b0;
      r[IR_BIT_R] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ir_debouncer.sv
// Two-flop synchroniser followed by a whole-vector debouncer: the vector must
// hold unchanged for DEBOUNCE_CYCLES clocks before it is passed to 'stable'.
module ir_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEB_CNT_W       = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam logic [DEB_CNT_W-1:0] DCNT_MAX = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0]     cand_q, cand_d, stable_q, stable_d;
  logic [DEB_CNT_W-1:0] dcnt_q, dcnt_d;

  // Sync chain plus debounce window; any change restarts the window
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    stable_d = stable_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      stable_d = cand_q;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      dcnt_q   <= '0;
      stable_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/ir_command_scheduler.sv
// IR command scheduler: debounces the direction buttons, resolves them to a
// legal code and updates COMMAND / pack_gen_EN only at packet boundaries,
// emitting a one-cycle pack_strobe at each boundary while enabled.
// Optional feature macro: IR_SCHED_IDLE_TIMEOUT_EN -- stop the packet
// generator after IDLE_STROBES consecutive idle packets.
module ir_command_scheduler
  import ir_pkg::*;
#(
  parameter int STROBE_PERIOD   = 10_000_000,
  parameter int STROBE_CNT_W    = 24,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEB_CNT_W       = 20,
  parameter int IDLE_STROBES    = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       ENABLE,
  output logic [3:0] COMMAND,
  output logic       pack_strobe,
  output logic       pack_gen_EN
);

  localparam logic [STROBE_CNT_W-1:0] SCNT_MAX = STROBE_CNT_W'(STROBE_PERIOD - 1);

  logic [3:0]              btn_stable, code;
  logic                    en_s1_q, en_s1_d, en_s_q, en_s_d;
  logic [STROBE_CNT_W-1:0] scnt_q, scnt_d;
  logic [3:0]              cmd_q, cmd_d;
  logic                    strobe_q, strobe_d, gen_en_q, gen_en_d;
  logic                    wrap;

`ifdef IR_SCHED_IDLE_TIMEOUT_EN
  localparam int ICNT_W = $clog2(IDLE_STROBES + 1);
  localparam logic [ICNT_W-1:0] ICNT_MAX = ICNT_W'(IDLE_STROBES);
  logic [ICNT_W-1:0] icnt_q, icnt_d;
`endif

  ir_debouncer #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEB_CNT_W      (DEB_CNT_W)
  ) u_btn_deb (
    .CLK   (CLK),
    .RST   (RST),
    .din   (BTN),
    .stable(btn_stable)
  );

  assign code = ir_resolve(btn_stable);
  assign wrap = (scnt_q == SCNT_MAX);

  // Strobe counter and packet-boundary updates of the registered outputs
  always_comb begin
    en_s1_d  = ENABLE;
    en_s_d   = en_s1_q;
    scnt_d   = wrap ? '0 : scnt_q + 1'b1;
    cmd_d    = cmd_q;
    strobe_d = 1'b0;
    gen_en_d = gen_en_q;
`ifdef IR_SCHED_IDLE_TIMEOUT_EN
    icnt_d   = en_s_q ? icnt_q : '0;
`endif
    if (wrap) begin
      cmd_d = code;
`ifdef IR_SCHED_IDLE_TIMEOUT_EN
      if (!en_s_q) begin
        strobe_d = 1'b0;
        gen_en_d = 1'b0;
      end else if (code != IR_IDLE) begin
        // activity resumes transmission at this very boundary
        icnt_d   = '0;
        strobe_d = 1'b1;
        gen_en_d = 1'b1;
      end else if (icnt_q == ICNT_MAX) begin
        // timed out: stay quiet, counter saturated
        strobe_d = 1'b0;
        gen_en_d = 1'b0;
      end else begin
        icnt_d   = icnt_q + 1'b1;
        strobe_d = 1'b1;
        gen_en_d = 1'b1;
      end
`else
      strobe_d = en_s_q;
      gen_en_d = en_s_q;
`endif
    end
  end

  // Registers; reset wins over everything, including mid-packet
  always_ff @(posedge CLK) begin
    if (!RST) begin
      en_s1_q  <= 1'b0;
      en_s_q   <= 1'b0;
      scnt_q   <= '0;
      cmd_q    <= '0;
      strobe_q <= 1'b0;
      gen_en_q <= 1'b0;
`ifdef IR_SCHED_IDLE_TIMEOUT_EN
      icnt_q   <= '0;
`endif
    end else begin
      en_s1_q  <= en_s1_d;
      en_s_q   <= en_s_d;
      scnt_q   <= scnt_d;
      cmd_q    <= cmd_d;
      strobe_q <= strobe_d;
      gen_en_q <= gen_en_d;
`ifdef IR_SCHED_IDLE_TIMEOUT_EN
      icnt_q   <= icnt_d;
`endif
    end
  end

  assign COMMAND     = cmd_q;
  assign pack_strobe = strobe_q;
  assign pack_gen_EN = gen_en_q;

endmodule

// File: tb/tb_ir_command_scheduler.sv
// Directed bench for ir_command_scheduler with STROBE_PERIOD=20,
// DEBOUNCE_CYCLES=4, IDLE_STROBES=3. 'edges' counts rising edges since the
// last reset release, so wraps land on multiples of 20.
module tb_ir_command_scheduler;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] BTN = 4'b0000;
  logic       ENABLE = 1'b0;
  logic [3:0] COMMAND;
  logic       pack_strobe, pack_gen_EN;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  ir_command_scheduler #(
    .STROBE_PERIOD  (20),
    .STROBE_CNT_W   (24),
    .DEBOUNCE_CYCLES(4),
    .DEB_CNT_W      (20),
    .IDLE_STROBES   (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN        (BTN),
    .ENABLE     (ENABLE),
    .COMMAND    (COMMAND),
    .pack_strobe(pack_strobe),
    .pack_gen_EN(pack_gen_EN)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    edges++;
  endtask

  task automatic run_to(input int target);
    while (edges < target) tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; BTN = 4'b1000; ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({COMMAND, pack_strobe, pack_gen_EN} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: COMMAND=%b strobe=%b en=%b, want 0000/0/0",
                 i, COMMAND, pack_strobe, pack_gen_EN);
      end
    end
    RST = 1'b1; edges = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      checks++;
      if (pack_strobe !== 1'b0) begin
        errors++;
        $display("FAIL reset_early_strobe edge %0d: strobe=%b, want 0", k, pack_strobe);
      end
    end
    tick();
    checks++;
    if (pack_strobe !== 1'b1 || pack_gen_EN !== 1'b1 || COMMAND !== 4'b1000) begin
      errors++;
      $display("FAIL reset_first_strobe: strobe=%b en=%b COMMAND=%b, want 1/1/1000",
               pack_strobe, pack_gen_EN, COMMAND);
    end
    tick();
    checks++;
    if (pack_strobe !== 1'b0) begin
      errors++;
      $display("FAIL strobe_width: strobe=%b one cycle later, want 0", pack_strobe);
    end
  endtask

  task automatic test_bounce();
    BTN = 4'b0000;
    run_to(40);
    checks++;
    if (COMMAND !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_idle: COMMAND=%b, want 0000", COMMAND);
    end
    run_to(50);
    for (int s = 0; s < 6; s++) begin
      BTN = (s % 2 == 0) ? 4'b1000 : 4'b0000;
      tick(); tick();
    end
    BTN = 4'b1000;  // settled after edge 62
    // wrap at edge 60 fell inside the bounce (checked below via held value)
    run_to(79);
    checks++;
    if (COMMAND !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_hold: COMMAND=%b before settle wrap, want 0000", COMMAND);
    end
    tick();
    checks++;
    if (COMMAND !== 4'b1000 || pack_strobe !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settle: COMMAND=%b strobe=%b, want 1000/1", COMMAND, pack_strobe);
    end
  endtask

  task automatic test_conflicts();
    logic [3:0] raw [4];
    logic [3:0] exp [4];
    raw[0] = 4'b1100; exp[0] = 4'b0000;
    raw[1] = 4'b1110; exp[1] = 4'b0010;
    raw[2] = 4'b1111; exp[2] = 4'b0000;
    raw[3] = 4'b1001; exp[3] = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      BTN = raw[i];
      run_to(100 + 20 * i);
      checks++;
      if (COMMAND !== exp[i] || pack_strobe !== 1'b1) begin
        errors++;
        $display("FAIL conflict BTN=%b: COMMAND=%b strobe=%b, want %b/1",
                 raw[i], COMMAND, pack_strobe, exp[i]);
      end
    end
  endtask

  task automatic test_disable();
    run_to(165);
    ENABLE = 1'b0; BTN = 4'b1010;
    run_to(179);
    checks++;
    if (pack_gen_EN !== 1'b1) begin
      errors++;
      $display("FAIL disable_early: en=%b before wrap, want 1", pack_gen_EN);
    end
    tick();
    checks++;
    if (pack_gen_EN !== 1'b0 || pack_strobe !== 1'b0 || COMMAND !== 4'b1010) begin
      errors++;
      $display("FAIL disable_wrap: en=%b strobe=%b COMMAND=%b, want 0/0/1010",
               pack_gen_EN, pack_strobe, COMMAND);
    end
    run_to(200);
    checks++;
    if (pack_strobe !== 1'b0) begin
      errors++;
      $display("FAIL disabled_strobe: strobe=%b, want 0", pack_strobe);
    end
    ENABLE = 1'b1;
    run_to(219);
    checks++;
    if (pack_gen_EN !== 1'b0 || pack_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reenable_early: en=%b strobe=%b, want 0/0", pack_gen_EN, pack_strobe);
    end
    tick();
    checks++;
    if (pack_gen_EN !== 1'b1 || pack_strobe !== 1'b1 || COMMAND !== 4'b1010) begin
      errors++;
      $display("FAIL reenable_wrap: en=%b strobe=%b COMMAND=%b, want 1/1/1010",
               pack_gen_EN, pack_strobe, COMMAND);
    end
  endtask

  task automatic test_reset_mid_run();
    run_to(230);
    RST = 1'b0;
    tick();
    checks++;
    if ({COMMAND, pack_strobe, pack_gen_EN} !== 6'b0) begin
      errors++;
      $display("FAIL midrun_reset: COMMAND=%b strobe=%b en=%b, want 0000/0/0",
               COMMAND, pack_strobe, pack_gen_EN);
    end
    RST = 1'b1; edges = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      checks++;
      if (pack_strobe !== 1'b0) begin
        errors++;
        $display("FAIL midrun_early_strobe edge %0d: strobe=%b, want 0", k, pack_strobe);
      end
    end
    tick();
    checks++;
    if (pack_strobe !== 1'b1 || pack_gen_EN !== 1'b1 || COMMAND !== 4'b1010) begin
      errors++;
      $display("FAIL midrun_first_strobe: strobe=%b en=%b COMMAND=%b, want 1/1/1010",
               pack_strobe, pack_gen_EN, COMMAND);
    end
  endtask

`ifdef IR_SCHED_IDLE_TIMEOUT_EN
  task automatic test_idle_timeout();
    BTN = 4'b0000;
    for (int w = 1; w <= 3; w++) begin
      run_to(20 + 20 * w);
      checks++;
      if (pack_strobe !== 1'b1 || pack_gen_EN !== 1'b1) begin
        errors++;
        $display("FAIL idle_wrap %0d: strobe=%b en=%b, want 1/1", w, pack_strobe, pack_gen_EN);
      end
    end
    run_to(100);
    checks++;
    if (pack_strobe !== 1'b0 || pack_gen_EN !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: strobe=%b en=%b, want 0/0", pack_strobe, pack_gen_EN);
    end
    BTN = 4'b0100;
    run_to(120);
    checks++;
    if (pack_strobe !== 1'b1 || pack_gen_EN !== 1'b1 || COMMAND !== 4'b0100) begin
      errors++;
      $display("FAIL idle_resume: strobe=%b en=%b COMMAND=%b, want 1/1/0100",
               pack_strobe, pack_gen_EN, COMMAND);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_conflicts();
    test_disable();
    test_reset_mid_run();
`ifdef IR_SCHED_IDLE_TIMEOUT_EN
    test_idle_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
